// File: rtl/ov7670_pkg.sv
// Shared OV7670 camera-control definitions: SCCB constants, frame layout and
// the write-master state encoding.
package ov7670_pkg;

  localparam logic [7:0]  SCCB_ID_WRITE  = 8'h42;
  localparam logic [15:0] INIT_END_WORD  = 16'hFFFF;
  localparam int unsigned SCCB_FRAME_LEN = 27;

  // Quarter-period counts per bus phase
  localparam int unsigned START_QUARTERS = 2;
  localparam int unsigned BIT_QUARTERS   = 4;
  localparam int unsigned STOP_QUARTERS  = 3;
  localparam int unsigned GAP_QUARTERS   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StShift,
    StStop,
    StGap
  } sccb_state_e;

  // Don't-care/ACK slots are filled with 1 so the released line level matches.
  function automatic logic [SCCB_FRAME_LEN-1:0] sccb_frame(input logic [7:0]  id,
                                                          input logic [15:0] word);
    return {id, 1'b1, word[15:8], 1'b1, word[7:0], 1'b1};
  endfunction

  // Bit indices 8, 17 and 26 (0-based, MSB first) are the slave's ninth-bit slots.
  function automatic logic is_ack_slot(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

endpackage

// File: rtl/sccb_quarter_tick.sv
// Free-running SIOC quarter-period strobe; clear restarts the count so the
// first tick lands exactly CLK_DIV cycles after it.
module sccb_quarter_tick #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LastCnt = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LastCnt);
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB 3-phase write master: ID, register address and value bytes, followed by
// a bus-free gap before acknowledging the init sequencer.
module sccb_write_master
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [7:0]  SLAVE_ID = SCCB_ID_WRITE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] data,
  output logic        ack,
  output logic        busy,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe
);

  localparam logic [1:0] StartLastQ = 2'(START_QUARTERS - 1);
  localparam logic [1:0] BitLastQ   = 2'(BIT_QUARTERS - 1);
  localparam logic [1:0] StopLastQ  = 2'(STOP_QUARTERS - 1);
  localparam logic [1:0] GapLastQ   = 2'(GAP_QUARTERS - 1);
  localparam logic [4:0] LastBit    = 5'(SCCB_FRAME_LEN - 1);

  sccb_state_e               state_q, state_d;
  logic [1:0]                quarter_q, quarter_d;
  logic [4:0]                bit_q, bit_d;
  logic [SCCB_FRAME_LEN-1:0] frame_q, frame_d;
  logic                      ack_q;
  logic                      accept;
  logic                      tick;

  // ack_q holds off acceptance for one cycle so busy visibly drops between writes.
  assign accept = (state_q == StIdle) && start && (data != INIT_END_WORD) && !ack_q;
  assign busy   = (state_q != StIdle) || accept;

  sccb_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_quarter_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    ack       = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StStart;
          quarter_d = '0;
          bit_d     = '0;
          frame_d   = sccb_frame(SLAVE_ID, data);
        end
      end

      StStart: begin
        if (tick) begin
          if (quarter_q == StartLastQ) begin
            state_d   = StShift;
            quarter_d = '0;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      StShift: begin
        if (tick) begin
          if (quarter_q == BitLastQ) begin
            quarter_d = '0;
            frame_d   = {frame_q[SCCB_FRAME_LEN-2:0], 1'b1};
            if (bit_q == LastBit) begin
              state_d = StStop;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      StStop: begin
        if (tick) begin
          if (quarter_q == StopLastQ) begin
            state_d   = StGap;
            quarter_d = '0;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      StGap: begin
        if (tick) begin
          if (quarter_q == GapLastQ) begin
            state_d   = StIdle;
            quarter_d = '0;
            ack       = 1'b1;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        quarter_d = '0;
        bit_d     = '0;
      end
    endcase
  end

  // Bus pins decode purely from registered state, so they move only on tick edges.
  always_comb begin
    sioc     = 1'b1;
    siod_oe  = 1'b0;
    siod_out = 1'b1;

    case (state_q)
      StStart: begin
        sioc     = (quarter_q == 2'd0);
        siod_oe  = 1'b1;
        siod_out = 1'b0;
      end

      StShift: begin
        sioc    = quarter_q[1];
        siod_oe = !is_ack_slot(bit_q);
        if (siod_oe) begin
          siod_out = frame_q[SCCB_FRAME_LEN-1];
        end
      end

      StStop: begin
        sioc     = (quarter_q != 2'd0);
        siod_oe  = 1'b1;
        siod_out = (quarter_q == 2'd2);
      end

      default: begin
        sioc     = 1'b1;
        siod_oe  = 1'b0;
        siod_out = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      quarter_q <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      ack_q     <= ack;
    end
  end

endmodule

// File: doc/sccb_write_master.md
SCCB_WRITE_MASTER -- requirements
Module: sccb_write_master

Interface
REQ-001 Parameter CLK_DIV, default 125, clk cycles per SIOC quarter-period (125 gives 100 kHz SIOC from 50 MHz); legal range 2..65535.
REQ-002 Parameter SLAVE_ID, default 8'h42, SCCB write ID byte.
REQ-003 Port clk  input  1  core clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  synchronous, active-low reset.
REQ-005 Port start  input  1  request one 3-phase write; sampled only in IDLE.
REQ-006 Port data  input  16  {register address[15:8], register value[7:0]}; captured in the cycle start is accepted.
REQ-007 Port ack  output  1  one-cycle pulse when a write, including bus-free gap, has completed; drives the init sequencer's continue input.
REQ-008 Port busy  output  1  high from acceptance until the cycle ack is asserted, inclusive.
REQ-009 Port sioc  output  1  SCCB clock, push-pull.
REQ-010 Port siod_out  output  1  SCCB data value when driven.
REQ-011 Port siod_oe  output  1  1 = drive siod_out onto SIOD; 0 = release (external pull-up).

Function
REQ-012 Quarter tick: free-running divider, reset to 0 on entering START, emits one tick every CLK_DIV cycles; all bus transitions happen on ticks.
REQ-013 States: IDLE, START, SHIFT, STOP, GAP.
REQ-014 IDLE: sioc=1, siod_oe=0, siod_out=1, busy=0; start=1 with data!=16'hFFFF -> latch 27-bit frame {SLAVE_ID,1'bx, data[15:8],1'bx, data[7:0],1'bx} MSB first, go START.
REQ-015 start=1 with data==16'hFFFF (end-of-table word) SHALL be ignored: no bus activity, no ack, busy stays 0.
REQ-016 start while busy=1 SHALL be ignored; data changes while busy SHALL not affect the frame in flight.
REQ-017 START, 2 quarters: q0 SIOD driven 0 with SIOC 1; q1 SIOC 0, SIOD 0.
REQ-018 SHIFT, 27 bits x 4 quarters: q0 SIOC 0 and SIOD updated; q1 SIOC 0; q2-q3 SIOC 1; SIOD stable while SIOC high.
REQ-019 Bits 9, 18, 27 (don't-care/ACK slots): siod_oe=0 for all 4 quarters; slave response is not sampled.
REQ-020 STOP, 3 quarters: q0 SIOC 0, SIOD 0 driven; q1 SIOC 1, SIOD 0; q2 SIOC 1, SIOD 1 then released.
REQ-021 GAP, 4 quarters: bus idle (sioc=1, siod_oe=0); then ack=1 for one cycle, busy falls the following cycle, return IDLE.
REQ-022 Latency: with acceptance cycle = cycle 0, ack asserts in cycle 117*CLK_DIV exactly (2+108+3+4 quarters).
REQ-023 start asserted in the same cycle as ack SHALL be ignored; a new request is accepted no earlier than the cycle after busy falls.
REQ-024 ack SHALL never assert for two consecutive cycles.

Reset
REQ-025 reset_n=0 at any clk edge, including mid-transaction: next state IDLE, sioc=1, siod_oe=0, siod_out=1, ack=0, busy=0, divider and bit counter 0; frame discarded, no ack issued.
REQ-026 After reset_n returns high the block SHALL accept start in the first cycle.

Structure
REQ-027 Shared package ov7670_pkg SHALL hold SCCB_ID_WRITE (8'h42), INIT_END_WORD (16'hFFFF), SCCB frame length (27) and the state enum.
REQ-028 One sub-module, sccb_quarter_tick (parameter CLK_DIV, inputs clk, reset_n, clear; output tick), SHALL provide the quarter-period strobe.

Verification
REQ-029 CLK_DIV=4, start with data=16'h1280 -> SIOD bit sequence 0100_0010 x 0001_0010 x 1000_0000 x sampled on SIOC rising edges; ack in cycle 468; busy high cycles 0..468.
REQ-030 start with data=16'hFFFF -> sioc stays 1, siod_oe stays 0, ack never asserts for 1000 cycles.
REQ-031 Start/stop check: SIOD falls while SIOC=1 exactly once before first bit, rises while SIOC=1 exactly once after last bit; no other SIOD change while SIOC=1.
REQ-032 start held high continuously with data=16'h1101 -> back-to-back writes, each ack 468 cycles after its acceptance, accepted cycle after busy falls, ack pulses 1 cycle wide.
REQ-033 reset_n low for 1 cycle at cycle 200 of a write -> next cycle sioc=1, siod_oe=0, busy=0; no ack; fresh start then completes normally.
REQ-034 data toggled to 16'h6b4a at cycle 50 of a 16'h1211 write -> bus carries 16'h1211 only.
